// File: rtl/bus_arbiter_pkg.sv
// Shared types and register addresses for the weighted round-robin bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } arb_state_e;

    localparam logic [4:0] ADDR_CTRL        = 5'h00;
    localparam logic [4:0] ADDR_MASK_LO     = 5'h01;
    localparam logic [4:0] ADDR_MASK_HI     = 5'h02;
    localparam logic [4:0] ADDR_WEIGHT_BASE = 5'h10;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority selector: first eligible index at or after start, wrapping.
module arb_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] start,
    output logic [N-1:0]    winner,
    output logic [ID_W-1:0] winner_id,
    output logic            any_valid
);

    int idx;

    always_comb begin
        winner    = '0;
        winner_id = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!any_valid && eligible[idx]) begin
                any_valid   = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_wrr.sv
// Weighted round-robin bus arbiter with enable mask, per-master burst credit and fixed-priority mode.
// Optional owner hold timeout is compiled in with the ARB_TIMEOUT_EN macro.
module bus_arbiter_wrr
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int WEIGHT_W       = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ID_W           = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    input  logic                   config_wr,
    input  logic [4:0]             config_addr,
    input  logic [7:0]             config_data
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    arb_mode_e               mode;
    logic [NUM_MASTERS-1:0]  mask;
    logic [WEIGHT_W-1:0]     weight [NUM_MASTERS];

    arb_state_e              state;
    logic [ID_W-1:0]         rr_ptr;
    logic [WEIGHT_W-1:0]     credit;

    logic [NUM_MASTERS-1:0]  eligible;
    logic [ID_W-1:0]         pick_start;
    logic [NUM_MASTERS-1:0]  pick_onehot;
    logic [ID_W-1:0]         pick_id;
    logic                    pick_valid;
    logic [WEIGHT_W-1:0]     pick_weight;
    logic [WEIGHT_W-1:0]     load_credit;
    logic                    owner_req;
    logic                    owner_done;
    logic                    owner_en;
    logic                    timeout_hit;
    logic                    release_now;
    logic [ID_W-1:0]         next_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= ARB_RR;
            mask <= '1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                weight[i] <= WEIGHT_W'(1);
            end
        end else if (config_wr) begin
            if (config_addr == ADDR_CTRL) begin
                mode <= arb_mode_e'(config_data[0]);
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (config_addr == ADDR_MASK_LO && i < 8) begin
                    mask[i] <= config_data[i % 8];
                end
                if (config_addr == ADDR_MASK_HI && i >= 8) begin
                    mask[i] <= config_data[i % 8];
                end
                if (config_addr == ADDR_WEIGHT_BASE + 5'(i)) begin
                    weight[i] <= config_data[WEIGHT_W-1:0];
                end
            end
        end
    end

    // Fixed-priority mode is the rotating selector anchored at index 0.
    assign eligible   = req & mask;
    assign pick_start = (mode == ARB_FIXED) ? '0 : rr_ptr;

    arb_rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .eligible  (eligible),
        .start     (pick_start),
        .winner    (pick_onehot),
        .winner_id (pick_id),
        .any_valid (pick_valid)
    );

    assign pick_weight = weight[pick_id];
    assign load_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
    assign owner_req   = req[grant_id];
    assign owner_done  = done[grant_id];
    assign owner_en    = mask[grant_id];
    assign next_ptr    = (grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + ID_W'(1);
    assign release_now = !owner_req || !owner_en || timeout_hit
                         || (owner_done && credit == WEIGHT_W'(1));

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [HOLD_W-1:0] hold_cnt;

    // A done pulse from the owner restarts the hold window, so it also suppresses the timeout.
    assign timeout_hit = (state == ST_GRANTED) && !owner_done
                         && (hold_cnt == HOLD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (state == ST_IDLE || owner_done) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            credit      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state       <= ST_GRANTED;
                        grant       <= pick_onehot;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        credit      <= load_credit;
                    end
                end
                ST_GRANTED: begin
                    if (release_now) begin
                        state       <= ST_IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        rr_ptr      <= next_ptr;
                        credit      <= '0;
                    end else if (owner_done) begin
                        credit <= credit - WEIGHT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_wrr.sv
// Self-checking bench for bus_arbiter_wrr: vector table, directed corner sequences and random traffic vs a model.
module tb_bus_arbiter_wrr;

    localparam int N    = 4;
    localparam int ID_W = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, done, grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            config_wr;
    logic [4:0]      config_addr;
    logic [7:0]      config_data;
`ifdef ARB_TIMEOUT_EN
    logic            timeout;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    bus_arbiter_wrr #(
        .NUM_MASTERS    (N),
        .WEIGHT_W       (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .config_wr   (config_wr),
        .config_addr (config_addr),
        .config_data (config_data)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    // Reference model: owner index (-1 when idle) plus config state, advanced once per edge.
    int       mOwner, mPtr, mCredit, mHold;
    bit       mFixed, mTimeout;
    bit [N-1:0] mMask;
    int       mWeight [N];

    function automatic void modelReset();
        mOwner = -1; mPtr = 0; mCredit = 0; mHold = 0;
        mFixed = 0; mTimeout = 0; mMask = '1;
        for (int i = 0; i < N; i++) mWeight[i] = 1;
    endfunction

    function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] d, input logic w,
                                      input logic [4:0] a, input logic [7:0] dat, input logic rst);
        int start, o, cand;
        bit rel;
        if (rst) begin
            modelReset();
            return;
        end
        mTimeout = 0;
        o = mOwner;
        if (o < 0) begin
            start = mFixed ? 0 : mPtr;
            for (int k = 0; k < N; k++) begin
                cand = (start + k) % N;
                if (mOwner < 0 && r[cand] && mMask[cand]) begin
                    mOwner  = cand;
                    mCredit = (mWeight[cand] == 0) ? 1 : mWeight[cand];
                end
            end
            mHold = 0;
        end else begin
            rel = !r[o] || !mMask[o];
            if (d[o]) begin
                if (mCredit == 1) rel = 1;
                else mCredit = mCredit - 1;
            end
`ifdef ARB_TIMEOUT_EN
            if (!d[o] && mHold == TO - 1) begin
                rel = 1;
                mTimeout = 1;
            end
            mHold = d[o] ? 0 : mHold + 1;
`endif
            if (rel) begin
                mPtr   = (o + 1) % N;
                mOwner = -1;
            end
        end
        if (w) begin
            if (a == 5'h00) mFixed = dat[0];
            if (a == 5'h01) mMask = dat[N-1:0];
            for (int i = 0; i < N; i++) if (int'(a) == 16 + i) mWeight[i] = int'(dat[3:0]);
        end
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic checkOutput(input string tag);
        logic [N-1:0] expGrant;
        expGrant = (mOwner < 0) ? '0 : N'(1) << mOwner;
        check({tag, ".grant"}, 32'(grant), 32'(expGrant));
        check({tag, ".grant_valid"}, 32'(grant_valid), 32'(mOwner >= 0));
        check({tag, ".grant_id"}, 32'(grant_id), (mOwner < 0) ? 0 : 32'(mOwner));
`ifdef ARB_TIMEOUT_EN
        check({tag, ".timeout"}, 32'(timeout), 32'(mTimeout));
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic [N-1:0] r, input logic [N-1:0] d,
                                 input logic w, input logic [4:0] a, input logic [7:0] dat,
                                 input logic rst);
        req = r; done = d; config_wr = w; config_addr = a; config_data = dat; reset = rst;
        @(posedge clk);
        modelStep(r, d, w, a, dat, rst);
        #1;
        checkOutput(tag);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic         wr;
        logic [4:0]   addr;
        logic [7:0]   data;
        logic [N-1:0] expGrant;
        int           expId;
    } vec_t;

    vec_t vecs[18];
    int   cnt1, cnt2, cnt3, tcount;
    logic [N-1:0] rr, dd;
    logic [4:0]   ra;
    int           sel;

    initial begin
        // Rotation with one idle cycle between owners, then a weight-3 burst on master 1.
        vecs[0]  = '{4'b1111, 4'b0000, 0, 5'h00, 8'h00, 4'b0001, 0};
        vecs[1]  = '{4'b1110, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[2]  = '{4'b1111, 4'b0000, 0, 5'h00, 8'h00, 4'b0010, 1};
        vecs[3]  = '{4'b1101, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[4]  = '{4'b1111, 4'b0000, 0, 5'h00, 8'h00, 4'b0100, 2};
        vecs[5]  = '{4'b1011, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[6]  = '{4'b1111, 4'b0000, 0, 5'h00, 8'h00, 4'b1000, 3};
        vecs[7]  = '{4'b0111, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[8]  = '{4'b1111, 4'b0000, 0, 5'h00, 8'h00, 4'b0001, 0};
        vecs[9]  = '{4'b1110, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[10] = '{4'b0000, 4'b0000, 1, 5'h11, 8'h03, 4'b0000, 0};
        vecs[11] = '{4'b0110, 4'b0000, 0, 5'h00, 8'h00, 4'b0010, 1};
        vecs[12] = '{4'b0110, 4'b0010, 0, 5'h00, 8'h00, 4'b0010, 1};
        vecs[13] = '{4'b0110, 4'b0000, 0, 5'h00, 8'h00, 4'b0010, 1};
        vecs[14] = '{4'b0110, 4'b0010, 0, 5'h00, 8'h00, 4'b0010, 1};
        vecs[15] = '{4'b0110, 4'b0010, 0, 5'h00, 8'h00, 4'b0000, 0};
        vecs[16] = '{4'b0110, 4'b0000, 0, 5'h00, 8'h00, 4'b0100, 2};
        vecs[17] = '{4'b0010, 4'b0000, 0, 5'h00, 8'h00, 4'b0000, 0};

        modelReset();
        applyStimulus("reset", '0, '0, 0, '0, '0, 1);
        applyStimulus("reset", '0, '0, 0, '0, '0, 1);
        check("reset_grant", 32'(grant), 0);
        check("reset_grant_id", 32'(grant_id), 0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].req, vecs[i].done, vecs[i].wr,
                          vecs[i].addr, vecs[i].data, 0);
            check($sformatf("vec%0d.table_grant", i), 32'(grant), 32'(vecs[i].expGrant));
            check($sformatf("vec%0d.table_id", i), 32'(grant_id), 32'(vecs[i].expId));
        end

        // Fixed priority: master 1 always beats master 3.
        applyStimulus("fixed_cfg", '0, '0, 1, 5'h00, 8'h01, 0);
        applyStimulus("fixed_w1", '0, '0, 1, 5'h11, 8'h01, 0);
        cnt1 = 0; cnt3 = 0;
        for (int i = 0; i < 12; i++) begin
            dd = (mOwner >= 0) ? N'(1) << mOwner : '0;
            applyStimulus("fixed", 4'b1010, dd, 0, '0, '0, 0);
            if (grant[1]) cnt1++;
            if (grant[3]) cnt3++;
        end
        check("fixed_m3_never", 32'(cnt3), 0);
        check("fixed_m1_granted", 32'(cnt1 > 0), 1);

        // Masking the current owner forces a release; masked master is skipped afterwards.
        applyStimulus("mask_rr", '0, '0, 1, 5'h00, 8'h00, 0);
        applyStimulus("mask_own2", 4'b0100, '0, 0, '0, '0, 0);
        check("mask_own2_grant", 32'(grant), 32'h4);
        applyStimulus("mask_wr", 4'b0100, '0, 1, 5'h01, 8'h0B, 0);
        applyStimulus("mask_drop", 4'b0100, '0, 0, '0, '0, 0);
        check("mask_drop_grant", 32'(grant), 0);
        cnt2 = 0;
        for (int i = 0; i < 12; i++) begin
            rr = (mOwner >= 0) ? (4'b1111 & ~(N'(1) << mOwner)) : 4'b1111;
            applyStimulus("mask_skip", rr, '0, 0, '0, '0, 0);
            if (grant[2]) cnt2++;
        end
        check("mask_m2_skipped", 32'(cnt2), 0);
        applyStimulus("mask_restore", '0, '0, 1, 5'h01, 8'h0F, 0);
        applyStimulus("mask_restored", 4'b0100, '0, 0, '0, '0, 0);
        check("mask_restored_grant", 32'(grant), 32'h4);

        // Reset while master 3 owns the bus.
        applyStimulus("rst_idle", '0, '0, 0, '0, '0, 0);
        applyStimulus("rst_own3", 4'b1000, '0, 0, '0, '0, 0);
        check("rst_own3_grant", 32'(grant), 32'h8);
        applyStimulus("rst_hit", 4'b1000, '0, 0, '0, '0, 1);
        check("rst_hit_grant", 32'(grant), 0);
        applyStimulus("rst_regrant", 4'b1000, '0, 0, '0, '0, 0);
        check("rst_regrant_grant", 32'(grant), 32'h8);
        applyStimulus("rst_drop", 4'b0000, '0, 0, '0, '0, 0);
        applyStimulus("rst_ptr0", 4'b1111, '0, 0, '0, '0, 0);
        check("rst_ptr0_grant", 32'(grant), 32'h1);

`ifdef ARB_TIMEOUT_EN
        applyStimulus("to_rst", '0, '0, 0, '0, '0, 1);
        tcount = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus("timeout", 4'b0011, '0, 0, '0, '0, 0);
            if (timeout) tcount++;
            if (i == 8) check("timeout_grant_dropped", 32'(grant), 0);
            if (i == 9) check("timeout_next_owner", 32'(grant), 32'h2);
        end
        check("timeout_pulse_count", 32'(tcount), 1);
`endif

        // Random traffic including config writes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rr  = N'($urandom);
            dd  = N'($urandom) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
            sel = $urandom_range(0, 7);
            ra  = (sel < 3) ? 5'(sel) : (sel < 7) ? 5'(16 + sel - 3) : 5'($urandom_range(0, 31));
            applyStimulus("random", rr, dd, ($urandom_range(0, 7) == 0), ra, 8'($urandom),
                          ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
